// File: rtl/frame_ecc_pkg.sv
// Shared types and field widths for the frame ECC monitor.
package frame_ecc_pkg;

    localparam int unsigned FAR_W  = 26;
    localparam int unsigned WORD_W = 7;
    localparam int unsigned BIT_W  = 5;
    localparam int unsigned REC_W  = FAR_W + WORD_W + BIT_W;

    // Monitor control states: IDLE = queue empty, SERVICE = queue non-empty.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVICE = 2'd1,
        ST_HALT    = 2'd2
    } mon_state_e;

    // One correction request for the ICAP writer (38 bits).
    typedef struct packed {
        logic [FAR_W-1:0]  far;
        logic [WORD_W-1:0] word;
        logic [BIT_W-1:0]  bit_idx;
    } corr_rec_t;

endpackage

// File: rtl/frame_ecc_monitor_if.sv
// Syndrome input bus and correction-request handshake of the frame ECC monitor.
interface frame_ecc_monitor_if;
    import frame_ecc_pkg::*;

    logic              syndrome_valid;
    logic              ecc_error;
    logic              ecc_error_single;
    logic              crc_error;
    logic [FAR_W-1:0]  far;
    logic [WORD_W-1:0] synword;
    logic [BIT_W-1:0]  synbit;

    logic              corr_valid;
    logic              corr_ready;
    logic [FAR_W-1:0]  corr_far;
    logic [WORD_W-1:0] corr_word;
    logic [BIT_W-1:0]  corr_bit;

    // Producer of syndromes / consumer of correction requests.
    modport master (
        output syndrome_valid, ecc_error, ecc_error_single, crc_error,
        output far, synword, synbit, corr_ready,
        input  corr_valid, corr_far, corr_word, corr_bit
    );

    // The monitor itself.
    modport slave (
        input  syndrome_valid, ecc_error, ecc_error_single, crc_error,
        input  far, synword, synbit, corr_ready,
        output corr_valid, corr_far, corr_word, corr_bit
    );

endinterface

// File: rtl/frame_ecc_rec_fifo.sv
// Correction-record FIFO: synchronous push/pop, flush, full/empty status.
// Storage is reset so the head output reads zero after reset.
module frame_ecc_rec_fifo
    import frame_ecc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  corr_rec_t wr_data,
    output corr_rec_t rd_data,
    output logic      full,
    output logic      empty,
    output logic      one_left
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    corr_rec_t            mem_q [DEPTH];
    corr_rec_t            mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     count_q, count_d;

    // Pointer/occupancy update; flush overrides any push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = (count_q == OCC_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign one_left = (count_q == OCC_W'(1));

endmodule

// File: rtl/frame_ecc_monitor.sv
// Frame ECC monitor: classifies frame-check events, queues single-bit
// correction requests for the ICAP writer, halts on uncorrectable errors,
// and keeps saturating statistics.
// Optional feature macro: FRAME_ECC_MON_DEDUP_EN (suppress a record equal
// to the most recently queued one).
module frame_ecc_monitor
    import frame_ecc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    frame_ecc_monitor_if.slave bus,
    input  logic               clr_fatal,
    output logic               halted,
    output logic               crc_flag,
    output logic               ovf_flag,
    output logic               scan_done,
    output logic [CNT_W-1:0]   frames_cnt,
    output logic [CNT_W-1:0]   sbe_cnt,
    output logic [CNT_W-1:0]   mbe_cnt,
    output logic [CNT_W-1:0]   ovf_cnt,
    output logic [CNT_W-1:0]   scan_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    mon_state_e        state_q, state_d;
    logic              corr_valid_q, corr_valid_d;
    logic              halted_q, halted_d;
    logic              crc_flag_q, crc_flag_d;
    logic              ovf_flag_q, ovf_flag_d;
    logic              scan_done_q, scan_done_d;
    logic              have_prev_q, have_prev_d;
    logic [FAR_W-1:0]  prev_far_q, prev_far_d;
    logic [CNT_W-1:0]  frames_cnt_q, frames_cnt_d;
    logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d;
    logic [CNT_W-1:0]  mbe_cnt_q, mbe_cnt_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;

    logic      is_sbe_c, is_mbe_c, is_crc_c, halt_evt_c, in_halt_c;
    logic      push_try_c, push_c, pop_c, drop_c, flush_c, wrap_c, dup_c;
    logic      fifo_full, fifo_empty, fifo_one_left;
    corr_rec_t rec_c, head;

    // Event classification and queue control.
    always_comb begin
        is_sbe_c   = bus.syndrome_valid & bus.ecc_error & bus.ecc_error_single;
        is_mbe_c   = bus.syndrome_valid & bus.ecc_error & ~bus.ecc_error_single;
        is_crc_c   = bus.syndrome_valid & bus.crc_error;
        halt_evt_c = is_mbe_c | is_crc_c;
        in_halt_c  = (state_q == ST_HALT);
        rec_c      = '{far: bus.far, word: bus.synword, bit_idx: bus.synbit};
        pop_c      = corr_valid_q & bus.corr_ready & ~fifo_empty;
        push_try_c = is_sbe_c & ~in_halt_c & ~dup_c;
        push_c     = push_try_c & (~fifo_full | pop_c);
        drop_c     = push_try_c & fifo_full & ~pop_c;
        flush_c    = in_halt_c & clr_fatal & ~halt_evt_c;
        wrap_c     = bus.syndrome_valid & have_prev_q & (bus.far < prev_far_q);
    end

`ifdef FRAME_ECC_MON_DEDUP_EN
    corr_rec_t last_rec_q, last_rec_d;
    logic      last_vld_q, last_vld_d;

    // Track the most recently queued record; forgotten on flush.
    always_comb begin
        last_rec_d = last_rec_q;
        last_vld_d = last_vld_q;
        if (flush_c) begin
            last_rec_d = '0;
            last_vld_d = 1'b0;
        end else if (push_c) begin
            last_rec_d = rec_c;
            last_vld_d = 1'b1;
        end
    end

    // Last-pushed record register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rec_q <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_rec_q <= last_rec_d;
            last_vld_q <= last_vld_d;
        end
    end

    assign dup_c = last_vld_q & (rec_c == last_rec_q);
`else
    assign dup_c = 1'b0;
`endif

    frame_ecc_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_c),
        .pop      (pop_c),
        .flush    (flush_c),
        .wr_data  (rec_c),
        .rd_data  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .one_left (fifo_one_left)
    );

    // Next state and registered handshake/halt outputs; halt entry beats clr_fatal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (push_c) state_d = ST_SERVICE;
            ST_SERVICE: if (pop_c && !push_c && fifo_one_left) state_d = ST_IDLE;
            ST_HALT:    if (clr_fatal) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (halt_evt_c) state_d = ST_HALT;
        corr_valid_d = (state_d == ST_SERVICE);
        halted_d     = (state_d == ST_HALT);
    end

    // Flags, scan tracking and statistics counters.
    always_comb begin
        crc_flag_d   = flush_c ? 1'b0 : (crc_flag_q | is_crc_c);
        ovf_flag_d   = flush_c ? 1'b0 : (ovf_flag_q | drop_c);
        scan_done_d  = wrap_c;
        have_prev_d  = have_prev_q | bus.syndrome_valid;
        prev_far_d   = bus.syndrome_valid ? bus.far : prev_far_q;
        frames_cnt_d = sat_inc(frames_cnt_q, bus.syndrome_valid);
        sbe_cnt_d    = sat_inc(sbe_cnt_q, is_sbe_c);
        mbe_cnt_d    = sat_inc(mbe_cnt_q, is_mbe_c);
        ovf_cnt_d    = sat_inc(ovf_cnt_q, drop_c);
        scan_cnt_d   = sat_inc(scan_cnt_q, wrap_c);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            corr_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            crc_flag_q   <= 1'b0;
            ovf_flag_q   <= 1'b0;
            scan_done_q  <= 1'b0;
            have_prev_q  <= 1'b0;
            prev_far_q   <= '0;
            frames_cnt_q <= '0;
            sbe_cnt_q    <= '0;
            mbe_cnt_q    <= '0;
            ovf_cnt_q    <= '0;
            scan_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            corr_valid_q <= corr_valid_d;
            halted_q     <= halted_d;
            crc_flag_q   <= crc_flag_d;
            ovf_flag_q   <= ovf_flag_d;
            scan_done_q  <= scan_done_d;
            have_prev_q  <= have_prev_d;
            prev_far_q   <= prev_far_d;
            frames_cnt_q <= frames_cnt_d;
            sbe_cnt_q    <= sbe_cnt_d;
            mbe_cnt_q    <= mbe_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
        end
    end

    assign bus.corr_valid = corr_valid_q;
    assign bus.corr_far   = head.far;
    assign bus.corr_word  = head.word;
    assign bus.corr_bit   = head.bit_idx;
    assign halted         = halted_q;
    assign crc_flag       = crc_flag_q;
    assign ovf_flag       = ovf_flag_q;
    assign scan_done      = scan_done_q;
    assign frames_cnt     = frames_cnt_q;
    assign sbe_cnt        = sbe_cnt_q;
    assign mbe_cnt        = mbe_cnt_q;
    assign ovf_cnt        = ovf_cnt_q;
    assign scan_cnt       = scan_cnt_q;

endmodule
